instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Fetch stage directly upstream of the control unit.
- Drives the instruction memory address and captures the returned 16-bit instruction into a small prefetch FIFO.
- Presents the head instruction and its PC to the control unit over a valid/ready handshake.
- On a jump from the control unit, flushes the queue and redirects the fetch address; this replaces the control unit's hold/jump stalling of the PC.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- ADDR_W, 8, program address width; 256-word instruction space.
- INSTR_W, 16, instruction width.
- RESET_PC, 0, fetch address loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- fetch_en  in  1  permits fetching new instructions.
- imem_addr  out  ADDR_W  instruction memory address; always equals fetch_pc.
- imem_data  in  INSTR_W  instruction memory read data; combinational, valid in the same cycle as imem_addr.
- instr  out  INSTR_W  head-of-queue instruction.
- instr_pc  out  ADDR_W  address of the head instruction.
- instr_valid  out  1  queue non-empty.
- instr_ready  in  1  control unit accepts the head this cycle.
- jump  in  1  redirect request from the control unit.
- jump_target  in  ADDR_W  redirect address.
- count  out  clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (asynchronous, immediate, no clock edge needed):
  - fetch_pc = RESET_PC; read/write pointers = 0; count = 0.
  - All entry storage cleared to 0, so instr = 0 and instr_pc = 0.
  - instr_valid = 0; imem_addr = RESET_PC.
- Each entry holds {pc, instruction}.
- instr, instr_pc, instr_valid and count are driven from registered state only. There is no combinational path from instr_ready, jump or fetch_en to any output.
- instr_valid = (count != 0).
- pop = instr_valid && instr_ready. Ready while empty is a no-op; count never underflows.
- push = fetch_en && !jump && (count < DEPTH || pop):
  - push while full is allowed only with a simultaneous pop.
  - On push: entry[wr_ptr] <= {fetch_pc, imem_data}; wr_ptr increments; fetch_pc <= fetch_pc + 1.
- Arithmetic:
  - fetch_pc wraps modulo 2^ADDR_W (0xFF -> 0x00).
  - Pointers wrap modulo DEPTH.
- Count update:
  - push && pop: unchanged.
  - push only: +1.
  - pop only: -1.
  - neither: unchanged.
- Jump has priority over push and pop. On a posedge with jump = 1:
  - count <= 0; rd_ptr <= 0; wr_ptr <= 0; fetch_pc <= jump_target.
  - No push that cycle.
  - Any simultaneous pop is consumed by the CU but has no further effect on queue state.
- Following a jump:
  - Cycle after jump: instr_valid = 0 and imem_addr = jump_target.
  - If fetch_en = 1, the target instruction is pushed on that cycle's edge and is presented the cycle after.
  - Redirect latency: 2 cycles from jump edge to valid target.
- Back-to-back jumps: the last one wins; the queue stays empty.
- fetch_en = 0: no fetching, fetch_pc frozen; the queue still drains via pop.
- Reset asserted mid-operation discards all entries and pending fetches. After reset deasserts, fetching resumes from RESET_PC.
- Steady state (fetch_en = 1, ready = 1, no jump): throughput is one instruction per cycle.

Test Plan:
- Fill:
  - Stimulus: reset, then fetch_en = 1, instr_ready = 0, mem[i] = 16'hA000+i.
  - Required: after 4 edges count = 4, instr = A000, instr_pc = 00, imem_addr = 04; further edges leave count = 4 and imem_addr = 04.
- Streaming:
  - Stimulus: from the full state, hold instr_ready = 1.
  - Required: instr sequence A000, A001, A002, ... one per cycle; count stays 4; instr_pc increments by 1 per cycle.
- Jump flush:
  - Stimulus: with count = 3, pulse jump = 1, jump_target = 8'h40.
  - Required: next cycle count = 0, instr_valid = 0, imem_addr = 40; the cycle after, instr_valid = 1, instr = mem[40], instr_pc = 40.
- Wrap:
  - Stimulus: jump to 8'hFE, then fetch 3 entries with ready = 0.
  - Required: popping yields instr_pc FE, FF, 00 with mem[FE], mem[FF], mem[00].
- Drain/underflow:
  - Stimulus: count = 2, fetch_en = 0, ready = 1 for 4 cycles.
  - Required: two pops, then instr_valid = 0, count = 0; count stays 0 and imem_addr is unchanged.
- Async reset:
  - Stimulus: assert reset between clock edges with count = 3, fetch_pc = 12.
  - Required: without any edge, instr_valid = 0, count = 0, imem_addr = 00; first fetch after release stores pc 00.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Fetch stage: addresses instruction memory, buffers {pc, instr} pairs in a small
// prefetch FIFO and hands the head to the control unit. A jump flushes and redirects.
module instr_fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_data,
  output logic [INSTR_W-1:0]         instr,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  input  logic                       jump,
  input  logic [ADDR_W-1:0]          jump_target,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];

  logic w_pop;
  logic w_push;

  // Handshake: the head transfers on any edge where instr_valid && instr_ready;
  // instr_valid never depends on instr_ready, and a ready with an empty queue is ignored.
  assign w_pop  = (r_count != '0) && instr_ready;
  assign w_push = fetch_en && !jump && ((r_count < CNT_W'(DEPTH)) || w_pop);

  assign imem_addr   = r_fetch_pc;
  assign instr       = r_instr_mem[r_rd_ptr];
  assign instr_pc    = r_pc_mem[r_rd_ptr];
  assign instr_valid = (r_count != '0);
  assign count       = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= ADDR_W'(RESET_PC);
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (jump) begin
      // Redirect wins over any push/pop; stale storage is simply orphaned.
      r_fetch_pc <= jump_target;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
        r_instr_mem[r_wr_ptr] <= imem_data;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
        r_fetch_pc            <= r_fetch_pc + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: fill, stream, jump flush, address wrap,
// drain past empty and asynchronous reset mid-run.
module tb_instr_fetch_queue;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic [7:0]  jump_target;
  logic [2:0]  count;

  logic [15:0] mem [256];
  int total;
  int bad;

  instr_fetch_queue #(.DEPTH(4), .ADDR_W(8), .INSTR_W(16), .RESET_PC(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .jump_target (jump_target),
    .count       (count)
  );

  assign imem_data = mem[imem_addr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver: advance one edge, settle 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    reset       = 1'b1;
    fetch_en    = 1'b0;
    instr_ready = 1'b0;
    jump        = 1'b0;
    jump_target = 8'h00;

    // reset state
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_pc", 32'(instr_pc), 32'h0);
    check("rst_addr", 32'(imem_addr), 32'h0);
    step();
    reset = 1'b0;

    // fill with ready low
    fetch_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("fill_count", 32'(count), 32'(k));
    end
    check("fill_instr", 32'(instr), 32'hA000);
    check("fill_pc", 32'(instr_pc), 32'h00);
    check("fill_addr", 32'(imem_addr), 32'h04);
    step();
    step();
    check("full_hold_count", 32'(count), 32'd4);
    check("full_hold_addr", 32'(imem_addr), 32'h04);

    // streaming from full
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("stream_instr", 32'(instr), 32'hA000 + 32'(k));
      check("stream_pc", 32'(instr_pc), 32'(k));
      check("stream_count", 32'(count), 32'd4);
      step();
    end
    check("stream_addr", 32'(imem_addr), 32'h0A);

    // pop one without fetching to reach count = 3, then jump
    fetch_en = 1'b0;
    step();
    check("pre_jump_count", 32'(count), 32'd3);
    check("pre_jump_instr", 32'(instr), 32'hA007);
    fetch_en    = 1'b1;
    instr_ready = 1'b0;
    jump        = 1'b1;
    jump_target = 8'h40;
    step();
    jump = 1'b0;
    check("jump_count", 32'(count), 32'd0);
    check("jump_valid", 32'(instr_valid), 32'd0);
    check("jump_addr", 32'(imem_addr), 32'h40);
    step();
    check("jump_tgt_valid", 32'(instr_valid), 32'd1);
    check("jump_tgt_instr", 32'(instr), 32'hA040);
    check("jump_tgt_pc", 32'(instr_pc), 32'h40);
    check("jump_tgt_addr", 32'(imem_addr), 32'h41);

    // back-to-back jumps: last target wins, queue stays empty
    jump        = 1'b1;
    jump_target = 8'h80;
    step();
    jump_target = 8'hFE;
    step();
    jump = 1'b0;
    check("b2b_count", 32'(count), 32'd0);
    check("b2b_addr", 32'(imem_addr), 32'hFE);

    // wrap: fetch FE, FF, 00
    for (int k = 0; k < 3; k++) step();
    check("wrap_count", 32'(count), 32'd3);
    check("wrap_addr", 32'(imem_addr), 32'h01);
    fetch_en    = 1'b0;
    instr_ready = 1'b1;
    check("wrap_instr0", 32'(instr), 32'hA0FE);
    check("wrap_pc0", 32'(instr_pc), 32'hFE);
    step();

    // drain / underflow: count = 2, no fetching, ready held 4 cycles
    check("drain_start_count", 32'(count), 32'd2);
    check("wrap_instr1", 32'(instr), 32'hA0FF);
    check("wrap_pc1", 32'(instr_pc), 32'hFF);
    step();
    check("wrap_instr2", 32'(instr), 32'hA000);
    check("wrap_pc2", 32'(instr_pc), 32'h00);
    check("drain_count1", 32'(count), 32'd1);
    step();
    check("drain_valid", 32'(instr_valid), 32'd0);
    check("drain_count0", 32'(count), 32'd0);
    step();
    step();
    check("underflow_count", 32'(count), 32'd0);
    check("underflow_addr", 32'(imem_addr), 32'h01);

    // async reset with count = 3, fetch_pc = 12
    instr_ready = 1'b0;
    fetch_en    = 1'b1;
    jump        = 1'b1;
    jump_target = 8'h0F;
    step();
    jump = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("pre_rst_count", 32'(count), 32'd3);
    check("pre_rst_addr", 32'(imem_addr), 32'h12);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_addr", 32'(imem_addr), 32'h00);
    check("arst_instr", 32'(instr), 32'h0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_pc", 32'(instr_pc), 32'h00);
    check("post_rst_instr", 32'(instr), 32'hA000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
